jesd204b_rx_link_fsm: RTL and testbench

//  Downstream of jesd204b_rx_controller_slide: consumes its 32-bit (4-octet) 8b/10b-decoded lane word stream.

---
 rtl/jesd204b_rx_link_fsm.sv | 170 +++++++++++++++++
 tb/tb_jesd204b_rx_link_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_rx_link_fsm.sv
// JESD204B subclass-1 receive link bring-up: CGS, ILAS check/capture, DATA.
// Keeps the LMFC counter aligned to SYSREF and drives SYNC~ back to the transmitter.
module jesd204b_rx_link_fsm #(
    parameter int F             = 1,
    parameter int K             = 32,
    parameter int ILAS_MF       = 4,
    parameter int CGS_MIN_WORDS = 4,
    parameter int ERR_THRESH    = 4
) (
    input  logic         i_usrclk,
    input  logic         i_rst,
    input  logic [31:0]  i_data,
    input  logic [3:0]   i_charisk,
    input  logic [3:0]   i_disperr,
    input  logic [3:0]   i_notintable,
    input  logic         i_sysref,
    output logic         o_nsync,
    output logic         o_lmfc,
    output logic [111:0] o_ilas_cfg,
    output logic         o_ilas_done,
    output logic [31:0]  o_data,
    output logic         o_data_valid,
    output logic [7:0]   o_err_cnt
);
    // state          | meaning
    // CGS_INIT       | SYNC~ low, counting consecutive clean /K/ words
    // CGS_WAIT_LMFC  | enough /K/ seen, release SYNC~ at next LMFC
    // CGS_DONE       | SYNC~ high, waiting for the first /R/ of ILAS
    // ILAS           | checking ILAS multiframes, capturing MF1 config
    // DATA           | user data forwarded, error tally monitored

    localparam int MF_WORDS = F * K / 4;
    localparam int LW = (MF_WORDS > 1) ? $clog2(MF_WORDS) : 1;
    localparam int MW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
    localparam int RW = $clog2(CGS_MIN_WORDS + 1);

    typedef enum logic [2:0] {CGS_INIT, CGS_WAIT_LMFC, CGS_DONE, ILAS, DATA} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] run, run_nxt;
    logic [LW-1:0] widx, widx_nxt;
    logic [MW-1:0] mfi, mfi_nxt;
    logic [LW-1:0] lmfc_cnt, lmfc_cnt_nxt;
    logic          sysref_q;
    logic          k_prev;
    logic [7:0]    tally, tally_base, tally_nxt;
    logic [8:0]    tally_sum, err_sum;
    logic [3:0]    err_vec;
    logic [2:0]    n_err;
    logic          err_word, is_k, is_r, is_a, is_q, ilas_ok;

    assign err_vec  = i_disperr | i_notintable;
    assign n_err    = 3'($countones(err_vec));
    assign err_word = |err_vec;
    assign is_k     = (i_data == 32'hBCBC_BCBC) && (i_charisk == 4'hF);
    assign is_r     = (i_data[7:0] == 8'h1C) && i_charisk[0];
    assign is_q     = (i_data[15:8] == 8'h9C) && i_charisk[1];
    assign is_a     = (i_data[31:24] == 8'h7C) && i_charisk[3];

    assign ilas_ok = (widx != '0 || is_r)
                  && (widx != LW'(MF_WORDS - 1) || is_a)
                  && !(mfi == MW'(1) && widx == '0 && !is_q);

    // A SYSREF rising edge realigns the multiframe phase independently of the FSM.
    assign lmfc_cnt_nxt = (i_sysref && !sysref_q) ? '0 :
                          (lmfc_cnt == LW'(MF_WORDS - 1)) ? '0 : lmfc_cnt + 1'b1;

    assign tally_base = (lmfc_cnt == '0) ? 8'd0 : tally;
    assign tally_sum  = {1'b0, tally_base} + {6'b0, n_err};
    assign tally_nxt  = (state != DATA) ? 8'd0 : (tally_sum[8] ? 8'hFF : tally_sum[7:0]);
    assign err_sum    = {1'b0, o_err_cnt} + {6'b0, n_err};

    always_ff @(posedge i_usrclk) begin
        if (i_rst) begin
            state  <= CGS_INIT;
            run    <= '0;
            widx   <= '0;
            mfi    <= '0;
            tally  <= 8'd0;
            k_prev <= 1'b0;
        end else begin
            state  <= state_nxt;
            run    <= run_nxt;
            widx   <= widx_nxt;
            mfi    <= mfi_nxt;
            tally  <= tally_nxt;
            k_prev <= (state == DATA) && is_k;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = '0;
        widx_nxt  = widx;
        mfi_nxt   = mfi;
        case (state)
            CGS_INIT: begin
                if (is_k && !err_word) begin
                    if (run == RW'(CGS_MIN_WORDS - 1)) state_nxt = CGS_WAIT_LMFC;
                    else                               run_nxt   = run + 1'b1;
                end
            end
            CGS_WAIT_LMFC: begin
                if (!is_k || err_word) state_nxt = CGS_INIT;
                else if (o_lmfc)       state_nxt = CGS_DONE;
            end
            CGS_DONE: begin
                if (err_word) begin
                    state_nxt = CGS_INIT;
                end else if (!is_k) begin
                    if (is_r) begin
                        state_nxt = ILAS;
                        widx_nxt  = LW'(1);
                        mfi_nxt   = '0;
                    end else begin
                        state_nxt = CGS_INIT;
                    end
                end
            end
            ILAS: begin
                if (err_word || !ilas_ok) begin
                    state_nxt = CGS_INIT;
                end else if (widx == LW'(MF_WORDS - 1)) begin
                    widx_nxt = '0;
                    if (mfi == MW'(ILAS_MF - 1)) state_nxt = DATA;
                    else                         mfi_nxt   = mfi + 1'b1;
                end else begin
                    widx_nxt = widx + 1'b1;
                end
            end
            DATA: begin
                if (tally_sum >= 9'(ERR_THRESH) || (is_k && k_prev)) state_nxt = CGS_INIT;
            end
            default: state_nxt = CGS_INIT;
        endcase
    end

    always_comb begin
        o_nsync      = (state == CGS_DONE) || (state == ILAS) || (state == DATA);
        o_data_valid = (state == DATA);
        o_ilas_done  = (state == DATA);
    end

    always_ff @(posedge i_usrclk) begin
        if (i_rst) begin
            sysref_q   <= 1'b0;
            lmfc_cnt   <= '0;
            o_lmfc     <= 1'b0;
            o_data     <= 32'd0;
            o_err_cnt  <= 8'd0;
            o_ilas_cfg <= '0;
        end else begin
            sysref_q  <= i_sysref;
            lmfc_cnt  <= lmfc_cnt_nxt;
            o_lmfc    <= (lmfc_cnt_nxt == '0);
            o_data    <= i_data;
            o_err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
            // MF1 octets 2..15 live in words 0..3 of that multiframe.
            if (state == ILAS && mfi == MW'(1)) begin
                case (widx)
                    LW'(0):  o_ilas_cfg[15:0]   <= i_data[31:16];
                    LW'(1):  o_ilas_cfg[47:16]  <= i_data;
                    LW'(2):  o_ilas_cfg[79:48]  <= i_data;
                    LW'(3):  o_ilas_cfg[111:80] <= i_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jesd204b_rx_link_fsm.sv
// Directed bench for jesd204b_rx_link_fsm: expectations are queued as each word
// is driven and popped/compared once the clock edge has produced the outputs.
module tb_jesd204b_rx_link_fsm;
    localparam int MFW     = 8;
    localparam int NMF     = 4;
    localparam logic [31:0]  KW      = 32'hBCBC_BCBC;
    localparam logic [111:0] CFG_EXP = {32'h0103_1122, 32'h0102_1122, 32'h0605_0403, 16'h0201};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_data;
    logic [3:0]   i_charisk, i_disperr, i_notintable;
    logic         i_sysref;
    logic         o_nsync, o_lmfc, o_ilas_done, o_data_valid;
    logic [111:0] o_ilas_cfg;
    logic [31:0]  o_data;
    logic [7:0]   o_err_cnt;

    always #5 clk = ~clk;

    jesd204b_rx_link_fsm dut (
        .i_usrclk    (clk),
        .i_rst       (rst),
        .i_data      (i_data),
        .i_charisk   (i_charisk),
        .i_disperr   (i_disperr),
        .i_notintable(i_notintable),
        .i_sysref    (i_sysref),
        .o_nsync     (o_nsync),
        .o_lmfc      (o_lmfc),
        .o_ilas_cfg  (o_ilas_cfg),
        .o_ilas_done (o_ilas_done),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_err_cnt   (o_err_cnt)
    );

    typedef struct {
        string        tag;
        int           sel;
        logic [111:0] exp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   phase = 0;
    int   errm  = 0;
    logic sref_prev = 1'b0;
    logic lmfc_m    = 1'b0;

    function automatic logic [111:0] observe(input int sel);
        logic [111:0] r;
        r = '0;
        case (sel)
            0: r[0]    = o_nsync;
            1: r[0]    = o_lmfc;
            2: r       = o_ilas_cfg;
            3: r[0]    = o_ilas_done;
            4: r[31:0] = o_data;
            5: r[0]    = o_data_valid;
            6: r[7:0]  = o_err_cnt;
            default: r = '1;
        endcase
        return r;
    endfunction

    task automatic push(input string tag, input int sel, input logic [111:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic check_q();
        exp_t         e;
        logic [111:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = observe(e.sel);
            total++;
            assert (o === e.exp) else begin
                bad++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic step(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                        input logic [3:0] ni, input logic sr, input logic r,
                        input logic en, input logic ev, input logic ed);
        i_data = d; i_charisk = k; i_disperr = de; i_notintable = ni;
        i_sysref = sr; rst = r;
        if (r) begin
            phase = 0; sref_prev = 1'b0; lmfc_m = 1'b0; errm = 0;
            push("data", 4, 112'd0);
        end else begin
            if (sr && !sref_prev) phase = 0;
            else                  phase = (phase + 1) % MFW;
            sref_prev = sr;
            lmfc_m = (phase == 0);
            errm = errm + $countones(de | ni);
            if (errm > 255) errm = 255;
            push("data", 4, 112'(d));
        end
        push("lmfc", 1, 112'(lmfc_m));
        push("err_cnt", 6, 112'(errm));
        push("nsync", 0, 112'(en));
        push("valid", 5, 112'(ev));
        push("ilas_done", 3, 112'(ed));
        @(posedge clk);
        #1;
        check_q();
    endtask

    task automatic ws(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                      input logic en, input logic ev, input logic ed);
        step(d, k, de, 4'h0, 1'b0, 1'b0, en, ev, ed);
    endtask

    // Four clean /K/ words, then /K/ until the first LMFC; SYNC~ rises one cycle later.
    task automatic bring_up(input logic sr_first);
        logic l;
        for (int i = 0; i < 4; i++)
            step(KW, 4'hF, 4'h0, 4'h0, sr_first && (i == 0), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MFW + 1; i++) begin
            l = lmfc_m;
            ws(KW, 4'hF, 4'h0, l, 1'b0, 1'b0);
            if (l) break;
        end
    endtask

    function automatic logic [35:0] ilas_word(input int m, input int w);
        logic [31:0] d;
        logic [3:0]  k;
        d = {8'(m), 8'(w), 8'h11, 8'h22};
        k = 4'h0;
        if (w == 0) begin
            d[7:0] = 8'h1C; k[0] = 1'b1;
            if (m == 1) begin
                d[15:8] = 8'h9C; k[1] = 1'b1; d[31:16] = 16'h0201;
            end
        end
        if (m == 1 && w == 1) d = 32'h0605_0403;
        if (w == MFW - 1) begin
            d[31:24] = 8'h7C; k[3] = 1'b1;
        end
        return {k, d};
    endfunction

    task automatic ilas(input int bad_mf, input int stop_at);
        logic [35:0] kd;
        logic        fail, last;
        for (int m = 0; m < NMF; m++) begin
            for (int w = 0; w < MFW; w++) begin
                kd = ilas_word(m, w);
                fail = (m == bad_mf) && (w == MFW - 1);
                if (fail) begin
                    kd[31:24] = 8'h33; kd[35] = 1'b0;
                end
                last = (m == NMF - 1) && (w == MFW - 1);
                ws(kd[31:0], kd[35:32], 4'h0, !fail, last, last);
                if (fail || (m * MFW + w) == stop_at) return;
            end
        end
    endtask

    task automatic pad_to(input int c);
        while (phase != c) ws(32'hA000_0000 | 32'(phase), 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        rst = 1'b1; i_data = '0; i_charisk = '0; i_disperr = '0; i_notintable = '0; i_sysref = 1'b0;

        // T1: reset values, CGS with SYSREF alignment
        push("cfg_reset", 2, 112'd0);
        step(KW, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(KW, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bring_up(1'b1);
        ws(KW, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);

        // T2: legal ILAS then first data word
        ilas(-1, -1);
        push("cfg_t2", 2, CFG_EXP);
        ws(32'h1234_5678, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);

        // T4: errors split across an MF boundary survive; inside one MF they re-sync
        pad_to(MFW - 1);
        ws(32'hE000_0001, 4'h0, 4'b0011, 1'b1, 1'b1, 1'b1);
        ws(32'hE000_0002, 4'h0, 4'b0011, 1'b1, 1'b1, 1'b1);
        pad_to(0);
        pad_to(2);
        ws(32'hE000_0003, 4'h0, 4'b0011, 1'b1, 1'b1, 1'b1);
        ws(32'hE000_0004, 4'h0, 4'b0011, 1'b0, 1'b0, 1'b0);

        // T3: missing /A/ at end of MF2
        bring_up(1'b0);
        ilas(2, -1);
        push("cfg_t3", 2, CFG_EXP);
        ws(32'h0000_0055, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // T5: single /K/ in DATA is tolerated, two in a row re-sync
        bring_up(1'b0);
        ilas(-1, -1);
        ws(32'hCAFE_0001, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        ws(KW, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        ws(32'hCAFE_0002, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        ws(KW, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        ws(KW, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);

        // not-in-table errors count alongside disparity errors
        step(32'h0000_0000, 4'h0, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // T6: reset in ILAS MF2, then a clean bring-up
        bring_up(1'b0);
        ilas(-1, 2 * MFW + 2);
        push("cfg_rst", 2, 112'd0);
        step(KW, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bring_up(1'b0);
        ilas(-1, -1);
        push("cfg_t6", 2, CFG_EXP);
        ws(32'h8765_4321, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);

        // error counter saturation; the first all-error word also trips the tally
        for (int i = 0; i < 70; i++)
            ws(32'h0000_0F00 | 32'(i), 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
